adc_clkdiv_ctrl: RTL and testbench
==================================

ADC_CLKDIV_CTRL -- requirements
Module: adc_clkdiv_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 8: width of ratio fields.
REQ-002 SHALL have parameter DIV_DEFAULT, default 4: ratio applied out of reset (even, >=2).
REQ-003 SHALL have parameter GATE_WAIT, default 2: cycles output held low before a new ratio loads (>=1).
REQ-004 SHALL have ports: clk_in_pre  in  1  clock; all logic on rising edge.
REQ-005 SHALL have ports: rstn_out  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: run_en  in  1  level; enables divided output.
REQ-007 SHALL have ports: cfg_req  in  1  single-cycle pulse requesting ratio cfg_div_n.
REQ-008 SHALL have ports: cfg_div_n  in  DIV_W  requested ratio; sampled with cfg_req.
REQ-009 SHALL have ports: cfg_ack  out  1  one-cycle pulse: ratio applied.
REQ-010 SHALL have ports: cfg_err  out  1  one-cycle pulse: request rejected.
REQ-011 SHALL have ports: cfg_busy  out  1  high in DRAIN, HOLD, LOAD.
REQ-012 SHALL have ports: div_out  out  1  divided clock, driven directly from a flop.
REQ-013 SHALL have ports: div_active  out  1  high in RUN only.
REQ-014 SHALL have ports: cur_div_n  out  DIV_W  currently applied ratio.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DRAIN, HOLD, LOAD.
REQ-016 SHALL keep a half-period counter cnt, 0..cur_div_n/2-1, counting only in RUN and DRAIN; cnt==cur_div_n/2-1 is the boundary, at which cnt returns to 0.
REQ-017 SHALL, in RUN, toggle div_out at each boundary; period = cur_div_n cycles, 50% duty.
REQ-018 SHALL move IDLE->RUN when run_en=1, with cnt=0 and div_out=0; first rise after cur_div_n/2 cycles.
REQ-019 SHALL treat a request as valid iff cfg_div_n is even and >=2; invalid requests pulse cfg_err the next cycle, with no state or ratio change.
REQ-020 SHALL reject cfg_req while cfg_busy=1 with cfg_err; the in-flight change completes unaffected.
REQ-021 SHALL latch a valid request as pending; RUN->DRAIN on a valid cfg_req or on run_en=0.
REQ-022 SHALL, in DRAIN, exit at the next boundary with div_out forced to 0: toggle if high, hold if low. No phase is shortened.
REQ-023 SHALL go DRAIN->HOLD if a request is pending, else DRAIN->IDLE.
REQ-024 SHALL stay in HOLD for GATE_WAIT cycles with div_out=0, then go to LOAD.
REQ-025 SHALL, in LOAD (one cycle), update cur_div_n from the pending ratio, clear cnt, and assert cfg_ack; next state is RUN if run_en=1, else IDLE.
REQ-026 SHALL move IDLE->LOAD on a valid cfg_req; if run_en also rises, the load is applied first.
REQ-027 SHALL give a simultaneous valid cfg_req and run_en=0 in RUN the path DRAIN->HOLD->LOAD->IDLE.
REQ-028 SHALL ignore run_en changes while in DRAIN, HOLD or LOAD until LOAD resolves.
REQ-029 SHALL drive div_out with no combinational path, so it never glitches.

Reset
REQ-030 SHALL, on rstn_out low, immediately set: state IDLE, cnt 0, div_out 0, cur_div_n DIV_DEFAULT, cfg_ack/cfg_err/cfg_busy/div_active 0, pending cleared.
REQ-031 SHALL drop any in-flight change on reset mid-operation, with no cfg_ack.

Structure
REQ-032 SHALL put the state encoding and the DIV_W default in a shared package adc_clkdiv_pkg.
REQ-033 SHALL implement the half-period counter as sub-module adc_clkdiv_halfcnt (inputs: enable, clear, half limit; output: boundary flag).

Verification
REQ-034 SHALL cover: reset, run_en=1, DIV_DEFAULT=4 -> div_out first rises 2 cycles after RUN entry, period 4, div_active=1.
REQ-035 SHALL cover: RUN ratio 4, cfg_req with cfg_div_n=8 while div_out high -> falls at boundary, 2 low cycles in HOLD, cfg_ack, then period 8, cur_div_n=8.
REQ-036 SHALL cover: cfg_req with cfg_div_n=5 (and 0) -> cfg_err for 1 cycle, cur_div_n unchanged, div_out cadence undisturbed.
REQ-037 SHALL cover: second cfg_req during HOLD -> cfg_err; the first change still acks with its own ratio.
REQ-038 SHALL cover: run_en=0 in RUN -> div_out completes its phase to 0 within cur_div_n/2 cycles, IDLE; then cfg_req 6 -> cfg_ack next cycle, cur_div_n=6.
REQ-039 SHALL cover: rstn_out asserted during HOLD -> all outputs at reset values immediately, no cfg_ack.

Source files
------------

// File: rtl/adc_clkdiv_pkg.sv
// Shared types for the ADC clock divider controller.
// State encoding and default ratio-field width.
package adc_clkdiv_pkg;

  localparam int DIV_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_HOLD,
    ST_LOAD
  } state_t;

endpackage

// File: rtl/adc_clkdiv_halfcnt.sv
// Half-period counter for the ADC clock divider.
// Counts 0..half_lim-1 while enabled; flags the wrap cycle.
module adc_clkdiv_halfcnt
  import adc_clkdiv_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk_in_pre,
  input  logic             rstn_out,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] half_lim,
  output logic             bnd
);

  logic [DIV_W-1:0] cnt;

  assign bnd = en && (cnt == half_lim - 1'b1);

  always_ff @(posedge clk_in_pre or negedge rstn_out) begin
    if (!rstn_out) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (bnd) cnt <= '0;
      else     cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adc_clkdiv_ctrl.sv
// ADC clock divider with glitch-free ratio changes.
// Output is drained low and gated before a new ratio loads.
module adc_clkdiv_ctrl
  import adc_clkdiv_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DIV_DEFAULT = 4,
  parameter int GATE_WAIT   = 2
) (
  input  logic             clk_in_pre,
  input  logic             rstn_out,
  input  logic             run_en,
  input  logic             cfg_req,
  input  logic [DIV_W-1:0] cfg_div_n,
  output logic             cfg_ack,
  output logic             cfg_err,
  output logic             cfg_busy,
  output logic             div_out,
  output logic             div_active,
  output logic [DIV_W-1:0] cur_div_n
);

  localparam int HW = (GATE_WAIT > 1) ? $clog2(GATE_WAIT) : 1;

  state_t           state, state_n;
  logic [DIV_W-1:0] cur_n, pend_div, pend_n;
  logic             pend_vld, pend_vld_n;
  logic             div_n, err_n;
  logic [HW-1:0]    hold_cnt, hold_n;
  logic             cnt_en, bnd, div_ok, take;

  assign cfg_busy   = (state == ST_DRAIN) ||
                      (state == ST_HOLD)  ||
                      (state == ST_LOAD);
  assign cfg_ack    = (state == ST_LOAD);
  assign div_active = (state == ST_RUN);

  assign div_ok = !cfg_div_n[0] && (cfg_div_n != '0);
  assign take   = cfg_req && div_ok && !cfg_busy;
  assign err_n  = cfg_req && (cfg_busy || !div_ok);
  assign cnt_en = (state == ST_RUN) || (state == ST_DRAIN);

  adc_clkdiv_halfcnt #(.DIV_W(DIV_W)) u_halfcnt (
    .clk_in_pre (clk_in_pre),
    .rstn_out   (rstn_out),
    .en         (cnt_en),
    .clr        (!cnt_en),
    .half_lim   (cur_div_n >> 1),
    .bnd        (bnd)
  );

  always_comb begin
    state_n    = state;
    cur_n      = cur_div_n;
    pend_n     = pend_div;
    pend_vld_n = pend_vld;
    div_n      = div_out;
    hold_n     = '0;
    unique case (state)
      ST_IDLE: begin
        div_n = 1'b0;
        if (take) begin
          pend_n     = cfg_div_n;
          pend_vld_n = 1'b1;
          state_n    = ST_LOAD;
        end else if (run_en) begin
          state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bnd) div_n = !div_out;
        if (take) begin
          pend_n     = cfg_div_n;
          pend_vld_n = 1'b1;
          state_n    = ST_DRAIN;
        end else if (!run_en) begin
          state_n = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // a low phase just runs out; a high phase ends with the fall
        if (bnd) begin
          div_n   = 1'b0;
          state_n = pend_vld ? ST_HOLD : ST_IDLE;
        end
      end
      ST_HOLD: begin
        div_n  = 1'b0;
        hold_n = hold_cnt + 1'b1;
        if (hold_cnt == HW'(GATE_WAIT - 1)) begin
          hold_n  = '0;
          state_n = ST_LOAD;
        end
      end
      ST_LOAD: begin
        div_n      = 1'b0;
        cur_n      = pend_div;
        pend_vld_n = 1'b0;
        state_n    = run_en ? ST_RUN : ST_IDLE;
      end
      default: begin
        div_n   = 1'b0;
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in_pre or negedge rstn_out) begin
    if (!rstn_out) begin
      state     <= ST_IDLE;
      cur_div_n <= DIV_W'(DIV_DEFAULT);
      pend_div  <= '0;
      pend_vld  <= 1'b0;
      div_out   <= 1'b0;
      cfg_err   <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_n;
      cur_div_n <= cur_n;
      pend_div  <= pend_n;
      pend_vld  <= pend_vld_n;
      div_out   <= div_n;
      cfg_err   <= err_n;
      hold_cnt  <= hold_n;
    end
  end

endmodule

// File: tb/tb_adc_clkdiv_ctrl.sv
// Directed bench for adc_clkdiv_ctrl.
// Checks follow hand-derived cycle timing from RUN entry.
module tb_adc_clkdiv_ctrl;

  logic       clk_in_pre = 1'b0;
  logic       rstn_out;
  logic       run_en;
  logic       cfg_req;
  logic [7:0] cfg_div_n;
  logic       cfg_ack, cfg_err, cfg_busy;
  logic       div_out, div_active;
  logic [7:0] cur_div_n;

  int checks = 0;
  int errors = 0;
  int t = 0;

  always #5 clk_in_pre = !clk_in_pre;

  adc_clkdiv_ctrl dut (
    .clk_in_pre (clk_in_pre),
    .rstn_out   (rstn_out),
    .run_en     (run_en),
    .cfg_req    (cfg_req),
    .cfg_div_n  (cfg_div_n),
    .cfg_ack    (cfg_ack),
    .cfg_err    (cfg_err),
    .cfg_busy   (cfg_busy),
    .div_out    (div_out),
    .div_active (div_active),
    .cur_div_n  (cur_div_n)
  );

  task automatic tick();
    @(posedge clk_in_pre);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // t counts cycles since RUN entry; div_out = floor(t/h) mod 2
  task automatic run_chk(string tag, int n, int h);
    for (int i = 0; i < n; i++) begin
      tick();
      t++;
      chk(tag, {31'd0, div_out}, 32'((t / h) % 2));
    end
  endtask

  task automatic chk_rst(string tag);
    chk({tag, "_ack"}, {31'd0, cfg_ack}, 0);
    chk({tag, "_err"}, {31'd0, cfg_err}, 0);
    chk({tag, "_busy"}, {31'd0, cfg_busy}, 0);
    chk({tag, "_div"}, {31'd0, div_out}, 0);
    chk({tag, "_act"}, {31'd0, div_active}, 0);
    chk({tag, "_cur"}, {24'd0, cur_div_n}, 4);
  endtask

  initial begin
    rstn_out  = 1'b0;
    run_en    = 1'b0;
    cfg_req   = 1'b0;
    cfg_div_n = 8'd0;
    tick();
    tick();
    chk_rst("reset");
    rstn_out = 1'b1;
    tick();

    // start running at default ratio 4
    run_en = 1'b1;
    tick();
    t = 0;
    chk("run_entry_act", {31'd0, div_active}, 1);
    chk("run_entry_div", {31'd0, div_out}, 0);
    run_chk("div4", 10, 2);

    // request ratio 8 while div_out high
    cfg_req   = 1'b1;
    cfg_div_n = 8'd8;
    tick();
    cfg_req = 1'b0;
    chk("drain_div", {31'd0, div_out}, 1);
    chk("drain_busy", {31'd0, cfg_busy}, 1);
    chk("drain_act", {31'd0, div_active}, 0);
    tick();
    chk("hold1_div", {31'd0, div_out}, 0);
    chk("hold1_busy", {31'd0, cfg_busy}, 1);
    tick();
    chk("hold2_div", {31'd0, div_out}, 0);
    chk("hold2_ack", {31'd0, cfg_ack}, 0);
    tick();
    chk("load_ack", {31'd0, cfg_ack}, 1);
    chk("load_cur", {24'd0, cur_div_n}, 4);
    tick();
    t = 0;
    chk("run8_ack", {31'd0, cfg_ack}, 0);
    chk("run8_cur", {24'd0, cur_div_n}, 8);
    chk("run8_act", {31'd0, div_active}, 1);
    run_chk("div8", 8, 4);

    // invalid ratios 5 and 0
    cfg_req   = 1'b1;
    cfg_div_n = 8'd5;
    run_chk("odd_cad", 1, 4);
    cfg_req = 1'b0;
    chk("odd_err", {31'd0, cfg_err}, 1);
    chk("odd_cur", {24'd0, cur_div_n}, 8);
    chk("odd_act", {31'd0, div_active}, 1);
    run_chk("odd_cad2", 1, 4);
    chk("odd_err_clr", {31'd0, cfg_err}, 0);
    cfg_req   = 1'b1;
    cfg_div_n = 8'd0;
    run_chk("zero_cad", 1, 4);
    cfg_req = 1'b0;
    chk("zero_err", {31'd0, cfg_err}, 1);
    chk("zero_cur", {24'd0, cur_div_n}, 8);
    run_chk("zero_cad2", 1, 4);
    chk("zero_err_clr", {31'd0, cfg_err}, 0);
    run_chk("div8_post", 6, 4);

    // ratio 4 request, second request during HOLD
    cfg_req   = 1'b1;
    cfg_div_n = 8'd4;
    tick();
    cfg_req = 1'b0;
    chk("r4_drain_busy", {31'd0, cfg_busy}, 1);
    chk("r4_drain_div", {31'd0, div_out}, 0);
    tick();
    chk("r4_hold_div", {31'd0, div_out}, 0);
    cfg_req   = 1'b1;
    cfg_div_n = 8'd6;
    tick();
    cfg_req = 1'b0;
    chk("busy_err", {31'd0, cfg_err}, 1);
    chk("busy_busy", {31'd0, cfg_busy}, 1);
    tick();
    chk("r4_ack", {31'd0, cfg_ack}, 1);
    chk("r4_err_clr", {31'd0, cfg_err}, 0);
    tick();
    t = 0;
    chk("r4_cur", {24'd0, cur_div_n}, 4);
    chk("r4_act", {31'd0, div_active}, 1);
    run_chk("div4b", 6, 2);

    // stop while div_out high
    run_en = 1'b0;
    tick();
    chk("stop_drain_div", {31'd0, div_out}, 1);
    chk("stop_drain_busy", {31'd0, cfg_busy}, 1);
    tick();
    chk("stop_idle_div", {31'd0, div_out}, 0);
    chk("stop_idle_busy", {31'd0, cfg_busy}, 0);
    chk("stop_idle_act", {31'd0, div_active}, 0);
    cfg_req   = 1'b1;
    cfg_div_n = 8'd6;
    tick();
    cfg_req = 1'b0;
    chk("idle_ack", {31'd0, cfg_ack}, 1);
    tick();
    chk("idle_ack_clr", {31'd0, cfg_ack}, 0);
    chk("idle_cur", {24'd0, cur_div_n}, 6);
    chk("idle_act", {31'd0, div_active}, 0);

    // reset during HOLD
    run_en = 1'b1;
    tick();
    chk("r6_act", {31'd0, div_active}, 1);
    cfg_req   = 1'b1;
    cfg_div_n = 8'd8;
    tick();
    cfg_req = 1'b0;
    tick();
    tick();
    chk("r6_hold_busy", {31'd0, cfg_busy}, 1);
    chk("r6_hold_div", {31'd0, div_out}, 0);
    rstn_out = 1'b0;
    #1;
    chk_rst("mid_rst");
    run_en = 1'b0;
    tick();
    tick();
    chk("mid_rst_ack", {31'd0, cfg_ack}, 0);
    rstn_out = 1'b1;
    tick();
    tick();
    chk("post_rst_ack", {31'd0, cfg_ack}, 0);
    chk("post_rst_cur", {24'd0, cur_div_n}, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
